// File: rtl/uart_baud_gen.sv
// uart_baud_gen: UART baud generator (tx_tick, rx_tick, tx_clk) with glitch-free rate switch on bit boundaries; ports clk, rst (sync active-low), en, baud_sel, cust_div, cust_load -> tx_tick, rx_tick, tx_clk, div_active, switch_pending; BAUD_CUSTOM_EN enables the custom divisor register
module uart_baud_gen #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       baud_sel,
  input  logic [DIV_W-1:0] cust_div,
  input  logic             cust_load,
  output logic             tx_tick,
  output logic             rx_tick,
  output logic             tx_clk,
  output logic [DIV_W-1:0] div_active,
  output logic             switch_pending
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

  function automatic logic [DIV_W-1:0] div_of(input longint baud);
    longint d;
    longint dmax;
    d = (longint'(CLK_FREQ) + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE);
    dmax = (longint'(1) << DIV_W) - 1;
    return DIV_W'(d < 2 ? 2 : d > dmax ? dmax : d);
  endfunction

  localparam logic [DIV_W-1:0] D_4800   = div_of(4800);
  localparam logic [DIV_W-1:0] D_9600   = div_of(9600);
  localparam logic [DIV_W-1:0] D_14400  = div_of(14400);
  localparam logic [DIV_W-1:0] D_19200  = div_of(19200);
  localparam logic [DIV_W-1:0] D_38400  = div_of(38400);
  localparam logic [DIV_W-1:0] D_57600  = div_of(57600);
  localparam logic [DIV_W-1:0] D_115200 = div_of(115200);

  logic [DIV_W-1:0] cust_sel, req, div_next, rx_cnt;
  logic [OS_W-1:0]  os_cnt;
  logic             run, wrap, bound;

`ifdef BAUD_CUSTOM_EN
  logic [DIV_W-1:0] cust;
  always_ff @(posedge clk)
    if (!rst) cust <= D_9600;
    else if (cust_load) cust <= cust_div < DIV_W'(2) ? DIV_W'(2) : cust_div;
  assign cust_sel = cust;
`else
  logic unused_cust;
  assign unused_cust = ^{cust_div, cust_load};
  assign cust_sel = D_9600;
`endif

  always_comb
    case (baud_sel)
      3'd0:    req = D_4800;
      3'd1:    req = D_9600;
      3'd2:    req = D_14400;
      3'd3:    req = D_19200;
      3'd4:    req = D_38400;
      3'd5:    req = D_57600;
      3'd6:    req = D_115200;
      default: req = cust_sel;
    endcase

  // run is en delayed by one edge, so the enabling edge itself leaves the
  // counter at 0 and the first rx_tick lands exactly div_active cycles later
  assign wrap     = run && rx_cnt == div_active - 1'b1;
  assign bound    = en && wrap && os_cnt == OS_LAST;
  assign div_next = (!en || bound) ? req : div_active;

  always_ff @(posedge clk)
    if (!rst) begin
      run            <= 1'b0;
      rx_cnt         <= '0;
      os_cnt         <= '0;
      tx_clk         <= 1'b0;
      tx_tick        <= 1'b0;
      rx_tick        <= 1'b0;
      switch_pending <= 1'b0;
      div_active     <= D_9600;
    end else begin
      run            <= en;
      div_active     <= div_next;
      switch_pending <= req != div_next;
      rx_tick        <= en && wrap;
      tx_tick        <= bound;
      rx_cnt         <= (en && run && !wrap) ? rx_cnt + 1'b1 : '0;
      os_cnt         <= !en ? '0 : wrap ? os_cnt + 1'b1 : os_cnt;
      tx_clk         <= !en ? 1'b0 : (wrap && os_cnt == OS_HALF) ? 1'b1 : (wrap && os_cnt == OS_LAST) ? 1'b0 : tx_clk;
    end
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: randomized scoreboard bench for uart_baud_gen at 1.8432 MHz, 16x oversampling
module tb_uart_baud_gen;
  localparam int F  = 1_843_200;
  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst, en, cust_load;
  logic [2:0]  baud_sel;
  logic [15:0] cust_div;
  logic        tx_tick, rx_tick, tx_clk, switch_pending;
  logic [15:0] div_active;

  uart_baud_gen #(.CLK_FREQ(F), .OVERSAMPLE(OS), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .baud_sel(baud_sel), .cust_div(cust_div),
    .cust_load(cust_load), .tx_tick(tx_tick), .rx_tick(rx_tick), .tx_clk(tx_clk),
    .div_active(div_active), .switch_pending(switch_pending)
  );

  always #5 clk = ~clk;

  typedef struct {int n; bit tx;} ev_t;
  ev_t q[$];
  int  compared = 0, mismatched = 0;
  int  edge_n = 0, mdiv = 12, mcust = 12, bstart = 0;
  bit  men = 1'b0, mpend = 1'b0, mclk = 1'b0, live = 1'b0;
  int  bauds[7] = '{4800, 9600, 14400, 19200, 38400, 57600, 115200};

  function automatic int dval(input int baud);
    int d;
    d = (F + baud * OS / 2) / (baud * OS);
    return d < 2 ? 2 : d > 65535 ? 65535 : d;
  endfunction

  function automatic int req_of(input int s, input int c);
    return s == 7 ? c : dval(bauds[s]);
  endfunction

  // Reference model: one bit lasts OS*div cycles from bstart; the k-th
  // rx_tick of a bit lands at bstart + k*div, and the 16th closes the bit.
  task automatic model_edge();
    int req, el, k;
    edge_n++;
    req = req_of(int'(baud_sel), mcust);
    if (!rst) begin
      mdiv = dval(9600); mcust = dval(9600); men = 0; mpend = 0; mclk = 0;
      return;
    end
    if (!en) begin
      mdiv = req; men = 0; mclk = 0;
    end else if (!men) begin
      men = 1; bstart = edge_n;
    end else begin
      el = edge_n - bstart;
      if (el % mdiv == 0) begin
        k = el / mdiv;
        mclk = k >= OS / 2 && k < OS;
        q.push_back('{edge_n, k == OS});
        if (k == OS) begin
          mdiv = req; bstart = edge_n;
        end
      end
    end
`ifdef BAUD_CUSTOM_EN
    if (cust_load) mcust = cust_div < 2 ? 2 : int'(cust_div);
`endif
    mpend = req != mdiv;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
    end
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_n);
    end
  endtask

  logic erx;
  ev_t  e;
  always @(negedge clk)
    if (live) begin
      erx = q.size() > 0 && q[0].n == edge_n;
      chk("rx_tick", 32'(rx_tick), 32'(erx));
      if (erx) begin
        e = q.pop_front();
        chk("tx_tick", 32'(tx_tick), 32'(e.tx));
      end else chk("tx_tick_idle", 32'(tx_tick), 32'd0);
      chk("tx_clk", 32'(tx_clk), 32'(mclk));
      chk("div_active", 32'(div_active), mdiv);
      chk("switch_pending", 32'(switch_pending), 32'(mpend));
    end

  initial begin
    rst = 0; en = 0; baud_sel = 3'd1; cust_div = '0; cust_load = 0;
    run(3);
    live = 1;
    rst = 1; run(2);
    en = 1; run(250);
    for (int i = 0; i < 400 && edge_n - bstart != 50; i++) run(1);
    baud_sel = 3'd3; run(400);
    baud_sel = 3'd6; run(200);
    baud_sel = 3'd1; run(300);
    en = 0; run(5);
    en = 1; run(400);
    cust_div = 16'd3; cust_load = 1; run(1);
    cust_load = 0; baud_sel = 3'd7; run(300);
    cust_div = 16'd0; cust_load = 1; run(1);
    cust_load = 0; run(300);
    baud_sel = 3'd3; run(400);
    run(50);
    rst = 0; run(1);
    rst = 1; run(400);
    for (int i = 0; i < 40; i++) begin
      baud_sel  = 3'($urandom_range(0, 7));
      en        = $urandom_range(0, 5) != 0;
      cust_div  = 16'($urandom_range(0, 40));
      cust_load = 1'($urandom_range(0, 1));
      run(1);
      cust_load = 0;
      run($urandom_range(1, 200));
    end
    en = 1; run(50);
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
